// File: rtl/sram_access_sequencer.sv
`timescale 1ns/1ps
// Sequences asynchronous 16-bit SRAM cycles for the AHB-Lite SRAM bridge.
// A 32-bit access is split into two half-word beats. Every output is registered:
// the next-state logic also produces next-cycle output values.
module sram_access_sequencer #(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2,
    parameter int unsigned TURN    = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        start,
    input  logic        wr,
    input  logic [19:0] addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [18:0] mem_addr,
    output logic [15:0] mem_dq_o,
    output logic        mem_dq_oe,
    input  logic [15:0] mem_dq_i,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_lb_n,
    output logic        mem_ub_n
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] RD_LOAD   = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD   = CW'(WR_WAIT - 1);
    localparam logic [CW-1:0] TURN_LOAD = (TURN > 0) ? CW'(TURN - 1) : '0;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, TURNA, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            beat_q, beat_d;
    logic            latch_en;

    logic            wr_q;
    logic [19:0]     addr_q;
    logic [2:0]      size_q;
    logic [31:0]     wdata_q;

    logic            src_wr;
    logic [19:0]     src_addr;
    logic [2:0]      src_size;
    logic [31:0]     src_wdata;
    logic            is_word;
    logic            is_half;
    logic            lb_sel_n;
    logic            ub_sel_n;
    logic [7:0]      byte_sel;

    logic [18:0]     beat_addr;
    logic [15:0]     beat_data;

    logic            done_d, busy_d, dq_oe_d;
    logic            ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;
    logic [31:0]     rdata_d;
    logic [18:0]     mem_addr_d;
    logic [15:0]     mem_dq_o_d;

    // Request fields: live inputs while accepting, latched copy afterwards
    assign src_wr    = (state_q == IDLE) ? wr    : wr_q;
    assign src_addr  = (state_q == IDLE) ? addr  : addr_q;
    assign src_size  = (state_q == IDLE) ? size  : size_q;
    assign src_wdata = (state_q == IDLE) ? wdata : wdata_q;
    assign is_word   = (src_size >= 3'd2);
    assign is_half   = (src_size == 3'd1);
    assign lb_sel_n  = !is_word && !is_half && src_addr[0];
    assign ub_sel_n  = !is_word && !is_half && !src_addr[0];
    assign byte_sel  = src_wdata[{src_addr[1:0], 3'b000} +: 8];

    // Next state, counters, read capture and next-cycle output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        latch_en   = 1'b0;
        rdata_d    = rdata;
        mem_addr_d = mem_addr;
        mem_dq_o_d = mem_dq_o;
        done_d     = 1'b0;
        dq_oe_d    = 1'b0;
        ce_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        lb_n_d     = 1'b1;
        ub_n_d     = 1'b1;
        beat_addr  = '0;
        beat_data  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    latch_en = 1'b1;
                    beat_d   = 1'b0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = wr_q ? WR_LOAD : RD_LOAD;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    if (!wr_q) begin
                        if (is_word) begin
                            if (beat_q) rdata_d[31:16] = mem_dq_i;
                            else        rdata_d[15:0]  = mem_dq_i;
                        end else begin
                            rdata_d = {mem_dq_i, mem_dq_i};
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (is_word && !beat_q) begin
                    beat_d  = 1'b1;
                    state_d = SETUP;
                end else if (TURN > 0) begin
                    cnt_d   = TURN_LOAD;
                    state_d = TURNA;
                end else begin
                    state_d = DONE;
                end
            end
            TURNA: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (is_word) begin
            beat_addr = {src_addr[19:2], beat_d};
            beat_data = beat_d ? src_wdata[31:16] : src_wdata[15:0];
        end else if (is_half) begin
            beat_addr = src_addr[19:1];
            beat_data = src_addr[1] ? src_wdata[31:16] : src_wdata[15:0];
        end else begin
            beat_addr = src_addr[19:1];
            beat_data = {byte_sel, byte_sel};
        end

        case (state_d)
            SETUP: begin
                ce_n_d     = 1'b0;
                lb_n_d     = lb_sel_n;
                ub_n_d     = ub_sel_n;
                dq_oe_d    = src_wr;
                mem_addr_d = beat_addr;
                if (src_wr) mem_dq_o_d = beat_data;
            end
            ACCESS: begin
                ce_n_d  = 1'b0;
                lb_n_d  = lb_sel_n;
                ub_n_d  = ub_sel_n;
                dq_oe_d = src_wr;
                oe_n_d  = src_wr;
                we_n_d  = !src_wr;
            end
            HOLD: begin
                ce_n_d  = 1'b0;
                lb_n_d  = lb_sel_n;
                ub_n_d  = ub_sel_n;
                dq_oe_d = src_wr;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            beat_q    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_dq_o  <= '0;
            mem_dq_oe <= 1'b0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_lb_n  <= 1'b1;
            mem_ub_n  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            done      <= done_d;
            busy      <= busy_d;
            rdata     <= rdata_d;
            mem_addr  <= mem_addr_d;
            mem_dq_o  <= mem_dq_o_d;
            mem_dq_oe <= dq_oe_d;
            mem_ce_n  <= ce_n_d;
            mem_oe_n  <= oe_n_d;
            mem_we_n  <= we_n_d;
            mem_lb_n  <= lb_n_d;
            mem_ub_n  <= ub_n_d;
        end
    end

    // Request capture on acceptance
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else if (latch_en) begin
            wr_q    <= wr;
            addr_q  <= addr;
            size_q  <= size;
            wdata_q <= wdata;
        end
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for sram_access_sequencer with a behavioural SRAM and byte-level reference memory.
module tb_sram_access_sequencer;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 3;
    localparam int TURN    = 1;

    logic        HCLK = 1'b0;
    logic        HRESETN = 1'b0;
    logic        start = 1'b0;
    logic        wr = 1'b0;
    logic [19:0] addr = '0;
    logic [2:0]  size = '0;
    logic [31:0] wdata = '0;
    logic        done;
    logic [31:0] rdata;
    logic        busy;
    logic [18:0] mem_addr;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe;
    logic [15:0] mem_dq_i = 16'hDEAD;
    logic        mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;

    sram_access_sequencer #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .start(start), .wr(wr), .addr(addr),
        .size(size), .wdata(wdata), .done(done), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
        .mem_dq_i(mem_dq_i), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n), .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit in_reset = 1'b1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural SRAM ----------------
    logic [15:0] sram [int];
    function automatic logic [15:0] init_pat(input int h);
        return 16'(h * 40503 + 4951);
    endfunction
    function automatic logic [15:0] sram_rd(input int h);
        if (sram.exists(h)) return sram[h];
        return init_pat(h);
    endfunction

    always @(negedge HCLK) begin
        logic [15:0] v;
        if (!mem_ce_n && !mem_we_n && mem_dq_oe) begin
            v = sram_rd(int'(mem_addr));
            if (!mem_lb_n) v[7:0]  = mem_dq_o[7:0];
            if (!mem_ub_n) v[15:8] = mem_dq_o[15:8];
            sram[int'(mem_addr)] = v;
        end
        mem_dq_i = (!mem_ce_n && !mem_oe_n) ? sram_rd(int'(mem_addr)) : 16'hDEAD;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_b [int];
    function automatic logic [7:0] ref_rd(input int a);
        logic [15:0] p;
        if (ref_b.exists(a)) return ref_b[a];
        p = init_pat(a / 2);
        return (a % 2 == 1) ? p[15:8] : p[7:0];
    endfunction
    function automatic logic [15:0] ref_hw(input int h);
        return {ref_rd(2 * h + 1), ref_rd(2 * h)};
    endfunction
    function automatic int latency(input bit w, input logic [2:0] sz);
        int wt;
        wt = w ? WR_WAIT : RD_WAIT;
        if (sz >= 3'd2) return 2 * (wt + 2) + TURN + 1;
        return 3 + wt + TURN;
    endfunction

    typedef struct { int cyc; logic [31:0] rd; } exp_t;
    exp_t        sbq [$];
    logic [31:0] last_rdata = '0;

    task automatic model_issue(input bit w, input logic [19:0] a, input logic [2:0] sz,
                               input logic [31:0] wd, input int done_cyc);
        int ai, base, off;
        logic [15:0] hw;
        exp_t e;
        ai = int'(a);
        if (w) begin
            if (sz == 3'd0) begin
                ref_b[ai] = 8'(wd >> (8 * a[1:0]));
            end else if (sz == 3'd1) begin
                base = ai & ~1;
                off  = 16 * a[1];
                ref_b[base]     = 8'(wd >> off);
                ref_b[base + 1] = 8'(wd >> (off + 8));
            end else begin
                base = ai & ~3;
                for (int i = 0; i < 4; i++) ref_b[base + i] = 8'(wd >> (8 * i));
            end
        end else begin
            if (sz >= 3'd2) begin
                base = (ai & ~3) / 2;
                last_rdata = {ref_hw(base + 1), ref_hw(base)};
            end else begin
                hw = ref_hw(ai / 2);
                last_rdata = {hw, hw};
            end
        end
        e.cyc = done_cyc;
        e.rd  = last_rdata;
        sbq.push_back(e);
    endtask

    task automatic preload(input int h, input logic [15:0] v);
        sram[h] = v;
        ref_b[2 * h]     = v[7:0];
        ref_b[2 * h + 1] = v[15:8];
    endtask

    // ---------------- current transaction timeline ----------------
    bit          cur_valid = 1'b0;
    int          cur_start = 0;
    int          cur_len   = 0;
    bit          cur_wr    = 1'b0;
    logic [19:0] cur_addr  = '0;
    logic [2:0]  cur_size  = '0;
    logic [31:0] cur_wdata = '0;
    int          idle_from = 0;

    // Done/rdata monitor: pops the scoreboard on every done pulse
    always @(negedge HCLK) begin
        exp_t e;
        if (!in_reset) begin
            if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                check("done_missing", 64'(0), 64'(1));
                void'(sbq.pop_front());
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    check("done_unexpected", 64'(1), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("rdata", 64'(rdata), 64'(e.rd));
                end
            end
        end
    end

    // Bus monitor: strobes, busy, address and write data against the access timeline
    always @(negedge HCLK) begin
        int k, wt, span, nb, b, p, ai;
        logic [6:0]  exp_v;
        logic [18:0] exp_a;
        logic [15:0] exp_d;
        logic [7:0]  bsel;
        if (!in_reset) begin
            exp_v = 7'b1111100;  // ce oe we lb ub dq_oe busy
            k = cyc - cur_start;
            if (cur_valid && k >= 1 && k <= cur_len) begin
                exp_v[0] = 1'b1;
                wt   = cur_wr ? WR_WAIT : RD_WAIT;
                span = wt + 2;
                nb   = (cur_size >= 3'd2) ? 2 : 1;
                ai   = int'(cur_addr);
                if (k <= nb * span) begin
                    b = (k - 1) / span;
                    p = (k - 1) % span;
                    exp_v[6] = 1'b0;
                    exp_v[1] = cur_wr;
                    if (cur_size == 3'd0) begin
                        exp_v[3] = cur_addr[0];
                        exp_v[2] = !cur_addr[0];
                    end else begin
                        exp_v[3] = 1'b0;
                        exp_v[2] = 1'b0;
                    end
                    if (p >= 1 && p <= wt) begin
                        if (cur_wr) exp_v[4] = 1'b0;
                        else        exp_v[5] = 1'b0;
                    end
                    if (cur_size >= 3'd2) begin
                        exp_a = 19'((ai & ~3) / 2 + b);
                        exp_d = 16'(cur_wdata >> (16 * b));
                    end else if (cur_size == 3'd1) begin
                        exp_a = 19'(ai / 2);
                        exp_d = 16'(cur_wdata >> (16 * cur_addr[1]));
                    end else begin
                        exp_a = 19'(ai / 2);
                        bsel  = 8'(cur_wdata >> (8 * cur_addr[1:0]));
                        exp_d = {bsel, bsel};
                    end
                    check("mem_addr", 64'(mem_addr), 64'(exp_a));
                    if (cur_wr) check("mem_dq_o", 64'(mem_dq_o), 64'(exp_d));
                end
            end
            check("strobes", 64'({mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n, mem_dq_oe, busy}),
                  64'(exp_v));
        end
    end

    always @(posedge HCLK) begin
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Issue one request once the sequencer is idle; optionally pulse start again while busy
    task automatic do_txn(input bit w, input logic [19:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input int gap, input bit poke);
        int l, k;
        while (cyc < idle_from) step();
        repeat (gap) step();
        start = 1'b1;
        wr    = w;
        addr  = a;
        size  = sz;
        wdata = wd;
        l = latency(w, sz);
        cur_start = cyc;
        cur_len   = l;
        cur_wr    = w;
        cur_addr  = a;
        cur_size  = sz;
        cur_wdata = wd;
        cur_valid = 1'b1;
        model_issue(w, a, sz, wd, cyc + l);
        idle_from = cyc + l + 1;
        step();
        start = 1'b0;
        wr    = 1'($urandom);
        addr  = 20'($urandom);
        size  = 3'($urandom);
        wdata = $urandom;
        if (poke) begin
            k = $urandom_range(1, l);
            repeat (k - 1) step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        bit          w;
        logic [19:0] a;
        logic [2:0]  sz;
        int          r, gap, t;
        bit          poke;

        repeat (2) @(posedge HCLK);
        #1;
        check("reset_values",
              64'({done, busy, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}),
              64'(8'b00011111));
        check("reset_data", 64'({rdata, mem_addr, mem_dq_o}), 64'(0));
        @(negedge HCLK);
        HRESETN = 1'b1;
        #1;
        in_reset = 1'b0;
        step();

        // word read across two beats
        preload(32'h82, 16'h1234);
        preload(32'h83, 16'hABCD);
        do_txn(1'b0, 20'h00104, 3'd2, 32'h0, 0, 1'b0);
        // byte write on the upper lane
        do_txn(1'b1, 20'h00003, 3'd0, 32'h5A000000, 1, 1'b0);
        // half write then half read back
        do_txn(1'b1, 20'h00006, 3'd1, 32'hBEEF0000, 1, 1'b0);
        do_txn(1'b0, 20'h00006, 3'd1, 32'h0, 1, 1'b0);
        // start pulses while busy
        do_txn(1'b0, 20'h00003, 3'd0, 32'h0, 1, 1'b1);
        do_txn(1'b1, 20'h00010, 3'd2, 32'hCAFEF00D, 0, 1'b1);
        // back-to-back word writes, start on the cycle after done
        do_txn(1'b1, 20'h00020, 3'd2, 32'h11223344, 0, 1'b0);
        do_txn(1'b1, 20'h00024, 3'd7, 32'h55667788, 0, 1'b0);
        do_txn(1'b0, 20'h00022, 3'd2, 32'h0, 0, 1'b0);

        // reset asserted during a write access
        do_txn(1'b1, 20'h00040, 3'd2, 32'hA5A5C3C3, 1, 1'b0);
        step();
        #2;
        check("we_low_before_reset", 64'(mem_we_n), 64'(0));
        in_reset = 1'b1;
        HRESETN  = 1'b0;
        #1;
        check("strobes_in_reset",
              64'({done, busy, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}),
              64'(8'b00011111));
        check("rdata_in_reset", 64'(rdata), 64'(0));
        sbq.delete();
        cur_valid  = 1'b0;
        last_rdata = '0;
        idle_from  = 0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETN = 1'b1;
        #1;
        in_reset = 1'b0;
        step();
        do_txn(1'b1, 20'h00040, 3'd2, 32'hA5A5C3C3, 0, 1'b0);
        do_txn(1'b0, 20'h00040, 3'd2, 32'h0, 1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 3);
            sz = (r == 3) ? 3'($urandom_range(3, 7)) : 3'(r);
            a = 20'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a[19:12] = 8'($urandom);
            gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
            poke = ($urandom_range(0, 4) == 0);
            do_txn(w, a, sz, $urandom, gap, poke);
        end

        t = 0;
        while (sbq.size() > 0 && t < 100) begin
            step();
            t++;
        end
        check("drain", 64'(sbq.size()), 64'(0));
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
